// File: rtl/qif_pkg.sv
// qif_pkg: shared widths, current limits and the 10->8 bit saturator used by
// the synaptic driver and the QIF membrane block.
//   SYN_W  : width of the signed synaptic current bus
//   ACC_W  : internal accumulation width (headroom for i - d + w)
//   sat8() : clamp a 10-bit signed value to 8 bits, reporting overflow
package qif_pkg;

  localparam int SYN_W = 8;
  localparam int ACC_W = 10;
  localparam int I_MAX = 127;
  localparam int I_MIN = -128;

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(I_MAX);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(I_MIN);

  typedef struct packed {
    logic signed [SYN_W-1:0] val;
    logic                    ovf;
  } sat_t;

  function automatic sat_t sat8(input logic signed [ACC_W-1:0] s);
    sat_t r;
    if (s > ACC_MAX) begin
      r.val = SYN_W'(I_MAX);
      r.ovf = 1'b1;
    end else if (s < ACC_MIN) begin
      r.val = SYN_W'(I_MIN);
      r.ovf = 1'b1;
    end else begin
      r.val = s[SYN_W-1:0];
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/qif_evt_fifo.sv
// qif_evt_fifo: synchronous event FIFO, DEPTH a power of two.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   clr_i      : synchronous clear (empties the FIFO)
//   push_i     : write din_i (ignored when full)
//   pop_i      : advance read pointer (ignored when empty)
//   dout_o     : head-of-queue data (valid when !empty_o)
//   count_o    : occupancy 0..DEPTH
//   full_o, empty_o : occupancy flags
module qif_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers are exactly AW bits wide, so wrap at DEPTH is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/qif_syn_drive.sv
// qif_syn_drive: presynaptic driver producing the signed synaptic current
// for a QIF neuron. Weighted spike events are buffered in a FIFO and popped
// at most one per cycle into a leaky, saturating current accumulator.
//   clk, rst_n          : clock, async active-low reset
//   en                  : enables pop and decay (FIFO still fills when low)
//   clr                 : synchronous clear of accumulator, FIFO and sat_flag
//   ev_valid/ev_ready   : event handshake, ev_weight signed 8-bit
//   i_syn               : registered signed synaptic current
//   fifo_count          : FIFO occupancy
//   sat_flag            : sticky, set whenever the accumulator clamps
module qif_syn_drive
  import qif_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int DECAY_SHIFT = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic [SYN_W-1:0]              ev_weight,
  output logic [SYN_W-1:0]              i_syn,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          sat_flag
);

  localparam logic [ACC_W-1:0] LEAK_MIN = ACC_W'(1 << DECAY_SHIFT);

  logic signed [SYN_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;

  logic                    fifo_full, fifo_empty, push, pop;
  logic [SYN_W-1:0]        fifo_dout;

  logic signed [ACC_W-1:0] acc_x, leak_s, w_x, sum;
  logic [ACC_W-1:0]        mag, leak_mag;
  sat_t                    sat_r;

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign ev_ready = !fifo_full;
  // A push coinciding with clr is dropped (the FIFO also gates it).
  assign push     = ev_valid && ev_ready && !clr;
  assign pop      = en && !clr && !fifo_empty;

  qif_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SYN_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (ev_weight),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Leak truncates toward zero; below 2^DECAY_SHIFT a unit step is taken
  // instead so the current always decays all the way to 0.
  always_comb begin
    acc_x    = {{(ACC_W-SYN_W){acc_q[SYN_W-1]}}, acc_q};
    mag      = acc_q[SYN_W-1] ? ACC_W'(-acc_x) : ACC_W'(acc_x);
    if (mag >= LEAK_MIN)  leak_mag = mag >> DECAY_SHIFT;
    else if (mag != '0)   leak_mag = ACC_W'(1);
    else                  leak_mag = '0;
    leak_s   = acc_q[SYN_W-1] ? -$signed(leak_mag) : $signed(leak_mag);
    w_x      = pop ? {{(ACC_W-SYN_W){fifo_dout[SYN_W-1]}}, fifo_dout} : '0;
    sum      = acc_x - leak_s + w_x;
    sat_r    = sat8(sum);
  end

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (en) begin
      acc_d = sat_r.val;
      sat_d = sat_q | sat_r.ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign i_syn    = acc_q;
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_qif_syn_drive.sv
// Scoreboard bench for qif_syn_drive (FIFO_DEPTH=4, DECAY_SHIFT=2).
// Stimulus pushes expected post-edge state tagged with the cycle it is due;
// the negedge monitor pops and compares every entry that has come due.
module tb_qif_syn_drive;

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0, ev_valid = 1'b0;
  logic [7:0] ev_weight = 8'h00;
  logic       ev_ready, sat_flag;
  logic [7:0] i_syn;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  qif_syn_drive #(.FIFO_DEPTH(4), .DECAY_SHIFT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_weight  (ev_weight),
    .i_syn      (i_syn),
    .fifo_count (fifo_count),
    .sat_flag   (sat_flag)
  );

  typedef struct {
    int    due;
    int    i;
    int    cnt;
    bit    sat;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0, nrun = 0, nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(string nm, int ei, int ec, bit es);
    bit er;
    er = (ec != 4);
    nrun++;
    if ($isunknown({i_syn, fifo_count, sat_flag, ev_ready}) ||
        int'($signed(i_syn)) != ei || int'(fifo_count) != ec ||
        sat_flag != es || ev_ready != er) begin
      nfail++;
      $display("FAIL %s: got i_syn=%0d count=%0d sat=%0b ready=%0b, want i_syn=%0d count=%0d sat=%0b ready=%0b",
               nm, $signed(i_syn), fifo_count, sat_flag, ev_ready, ei, ec, es, er);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      cmp(e.nm, e.i, e.cnt, e.sat);
    end
  end

  task automatic expect_at(int k, int ei, int ec, bit es, string nm);
    exp_t e;
    e.due = cyc + k; e.i = ei; e.cnt = ec; e.sat = es; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int w, bit e_, bit c);
    ev_valid  = v;
    ev_weight = 8'(w);
    en        = e_;
    clr       = c;
  endtask

  // One edge: drive inputs, expect (i_syn, count, sat) after that edge.
  task automatic step(bit v, int w, bit e_, bit c, int ei, int ec, bit es, string nm);
    drive(v, w, e_, c);
    expect_at(1, ei, ec, es, nm);
    tick();
  endtask

  int dec[17] = '{40, 30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0};

  initial begin
    #12;
    cmp("reset_init", 0, 0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single event decay from 0
    step(1, 40, 1, 0, 0, 1, 0, "dec_accept");
    drive(0, 0, 1, 0);
    for (int k = 0; k < 17; k++) expect_at(k + 1, dec[k], 0, 1'b0, $sformatf("decay%0d", k));
    repeat (17) tick();

    // Positive saturation
    step(1, 100, 1, 0, 0,   1, 0, "psat_push");
    step(1, 100, 1, 0, 100, 1, 0, "psat_pop1");
    step(0, 0,   1, 0, 127, 0, 1, "psat_pop2");

    // Negative saturation
    step(0, 0,    1, 1, 0,    0, 0, "clr1");
    step(1, -128, 1, 0, 0,    1, 0, "nsat_push");
    step(1, -128, 1, 0, -128, 1, 0, "nsat_pop1");
    step(0, 0,    1, 0, -128, 0, 1, "nsat_pop2");

    // Full, hold, ordering, simultaneous push/pop
    step(0, 0,  0, 1, 0, 0, 0, "clr2");
    step(1, 5,  0, 0, 0, 1, 0, "fill1");
    step(1, -3, 0, 0, 0, 2, 0, "fill2");
    step(1, 7,  0, 0, 0, 3, 0, "fill3");
    step(1, 1,  0, 0, 0, 4, 0, "fill4");
    step(1, 99, 0, 0, 0, 4, 0, "full_hold1");
    step(1, 99, 0, 0, 0, 4, 0, "full_hold2");
    step(0, 0,  1, 0, 5,  3, 0, "pop_5");
    step(0, 0,  1, 0, 1,  2, 0, "pop_m3");
    step(1, 9,  1, 0, 7,  2, 0, "pushpop_7");
    step(0, 0,  1, 0, 7,  1, 0, "pop_1");
    step(0, 0,  1, 0, 15, 0, 0, "pop_9");
    step(0, 0,  1, 0, 12, 0, 0, "decay_15");

    // clr with pending events, negative current and sticky sat
    step(0, 0,    1, 1, 0,    0, 0, "clr3");
    step(1, -128, 1, 0, 0,    1, 0, "c_push");
    step(1, -128, 1, 0, -128, 1, 0, "c_pop1");
    step(1, 46,   1, 0, -128, 1, 1, "c_pop2_sat");
    step(0, 0,    1, 0, -50,  0, 1, "c_m50");
    step(1, 10,   0, 0, -50,  1, 1, "c_q1");
    step(1, 20,   0, 0, -50,  2, 1, "c_q2");
    step(1, 30,   0, 0, -50,  3, 1, "c_q3");
    step(1, 77,   1, 1, 0,    0, 0, "clr_with_push");
    step(0, 0,    1, 0, 0,    0, 0, "clr_push_dropped");

    // Asynchronous reset mid-stream
    step(1, 57, 1, 0, 0,  1, 0, "r_push");
    step(0, 0,  1, 0, 57, 0, 0, "r_pop");
    step(1, 1,  0, 0, 57, 1, 0, "r_q1");
    step(1, 2,  0, 0, 57, 2, 0, "r_q2");
    step(1, 3,  0, 0, 57, 3, 0, "r_q3");
    drive(1, 4, 0, 0);
    #5;
    rst_n = 1'b0;
    #1;
    cmp("reset_async", 0, 0, 1'b0);
    drive(0, 0, 1, 0);
    #1;
    rst_n = 1'b1;
    tick();
    step(0, 0, 1, 0, 0, 0, 0, "post_reset");

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    if (sb.size() > 0) begin
      nrun++;
      nfail++;
      $display("FAIL drain: %0d expected entries never checked, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
